astar_heuristic_unit: RTL and testbench

//  Pipelined A* heuristic engine with an integrated result queue. Per accepted request it

---
 rtl/astar_heuristic_unit.sv | 140 ++++++++++++++
 tb/tb_astar_heuristic_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/astar_heuristic_unit.sv
// Pipelined scaled-Manhattan-distance engine for the A* worker, with a credit-guarded
// first-word-fall-through result queue that the consumer pops.
module astar_heuristic_unit #(
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned LOG_DEPTH = 6,
  parameter int unsigned K_LAT     = 1,
  parameter int unsigned K_LON     = 1,
  parameter int unsigned FRAC_BITS = 0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  output logic                 ap_ready,
  output logic                 ap_idle,
  output logic                 ap_done,
  input  logic [31:0]          src_lat_V,
  input  logic [31:0]          src_lon_V,
  input  logic [31:0]          dst_lat_V,
  input  logic [31:0]          dst_lon_V,
  output logic [31:0]          out_r,
  output logic                 out_r_ap_vld,
  input  logic                 rd_en,
  output logic [31:0]          rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [LOG_DEPTH:0]   size
);

  localparam int unsigned DEPTH   = 1 << LOG_DEPTH;
  localparam logic [15:0] K_LAT_W = 16'(K_LAT);
  localparam logic [15:0] K_LON_W = 16'(K_LON);

  // ---------------------------------------------------------------------------
  // Distance arithmetic, evaluated on the request cycle and then pipelined.
  // ---------------------------------------------------------------------------
  logic signed [32:0] dlat_s;
  logic signed [32:0] dlon_s;
  logic [32:0]        dlat_abs;
  logic [32:0]        dlon_abs;
  logic [49:0]        sum;
  logic [49:0]        sum_sh;
  logic [31:0]        result;

  always_comb begin
    dlat_s   = $signed({src_lat_V[31], src_lat_V}) - $signed({dst_lat_V[31], dst_lat_V});
    dlon_s   = $signed({src_lon_V[31], src_lon_V}) - $signed({dst_lon_V[31], dst_lon_V});
    // The most negative difference is -(2**32-1), so negation always fits in 33 bits.
    dlat_abs = dlat_s[32] ? $unsigned(-dlat_s) : $unsigned(dlat_s);
    dlon_abs = dlon_s[32] ? $unsigned(-dlon_s) : $unsigned(dlon_s);
    sum      = 50'(dlat_abs) * 50'(K_LAT_W) + 50'(dlon_abs) * 50'(K_LON_W);
    sum_sh   = sum >> FRAC_BITS;
    result   = (|sum_sh[49:32]) ? 32'hFFFF_FFFF : sum_sh[31:0];
  end

  // ---------------------------------------------------------------------------
  // Handshake, credits and FIFO control.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0]   vld_q, vld_d;
  logic [31:0]          data_q [LATENCY];
  logic [31:0]          data_d [LATENCY];
  logic [LOG_DEPTH:0]   inflight_q, inflight_d;
  logic [LOG_DEPTH:0]   size_q, size_d;
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]          mem_q [DEPTH];
  logic [LOG_DEPTH+1:0] credit_used;
  logic                 accept;
  logic                 push;
  logic                 pop;

  // Credits count both queued and in-flight results, so a push never meets a full queue.
  assign credit_used = {1'b0, size_q} + {1'b0, inflight_q};
  assign ap_ready    = !ap_rst && (credit_used < (LOG_DEPTH+2)'(DEPTH));
  assign accept      = ap_start && ap_ready;
  assign push        = vld_q[LATENCY-1];
  assign pop         = rd_en && (size_q != '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    vld_d     = vld_q;
    data_d    = data_q;
    vld_d[0]  = accept;
    data_d[0] = accept ? result : data_q[0];
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end

    inflight_d = inflight_q;
    unique case ({accept, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    size_d = size_q;
    unique case ({push, pop})
      2'b10:   size_d = size_q + 1'b1;
      2'b01:   size_d = size_q - 1'b1;
      default: size_d = size_q;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      vld_q      <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
      inflight_q <= '0;
      size_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      vld_q      <= vld_d;
      data_q     <= data_d;
      inflight_q <= inflight_d;
      size_q     <= size_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers alone define its contents.
  always_ff @(posedge ap_clk) begin
    if (push) mem_q[wr_ptr_q] <= data_q[LATENCY-1];
  end

  assign out_r        = data_q[LATENCY-1];
  assign out_r_ap_vld = vld_q[LATENCY-1];
  assign ap_done      = vld_q[LATENCY-1];
  assign ap_idle      = (inflight_q == '0) && !ap_start;
  assign rd_data      = mem_q[rd_ptr_q];
  assign empty        = (size_q == '0);
  assign full         = (size_q == (LOG_DEPTH+1)'(DEPTH));
  assign size         = size_q;

endmodule

// File: tb/tb_astar_heuristic_unit.sv
// Self-checking bench: a queue-based model of the engine plus directed vectors with
// hand-computed results, and a second instance with non-unit weights.
module tb_astar_heuristic_unit;

  localparam int LAT   = 3;
  localparam int DEPTH = 64;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_start = 1'b0, rd_en = 1'b0;
  logic [31:0] src_lat_V = '0, src_lon_V = '0, dst_lat_V = '0, dst_lon_V = '0;
  logic        ap_ready, ap_idle, ap_done, out_r_ap_vld, empty, full;
  logic [31:0] out_r, rd_data;
  logic [6:0]  size;

  logic        start2 = 1'b0;
  logic        ap_ready2, ap_idle2, ap_done2, out_r_ap_vld2, empty2, full2;
  logic [31:0] out_r2, rd_data2;
  logic [6:0]  size2;

  always #5 ap_clk = ~ap_clk;

  astar_heuristic_unit #(.LATENCY(LAT), .LOG_DEPTH(6), .K_LAT(1), .K_LON(1), .FRAC_BITS(0)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_idle(ap_idle), .ap_done(ap_done), .src_lat_V(src_lat_V), .src_lon_V(src_lon_V),
    .dst_lat_V(dst_lat_V), .dst_lon_V(dst_lon_V), .out_r(out_r), .out_r_ap_vld(out_r_ap_vld),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .size(size));

  astar_heuristic_unit #(.LATENCY(LAT), .LOG_DEPTH(6), .K_LAT(3), .K_LON(5), .FRAC_BITS(0)) dut2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(start2), .ap_ready(ap_ready2),
    .ap_idle(ap_idle2), .ap_done(ap_done2), .src_lat_V(src_lat_V), .src_lon_V(src_lon_V),
    .dst_lat_V(dst_lat_V), .dst_lon_V(dst_lon_V), .out_r(out_r2), .out_r_ap_vld(out_r_ap_vld2),
    .rd_en(1'b1), .rd_data(rd_data2), .empty(empty2), .full(full2), .size(size2));

  int n_cmp = 0;
  int n_bad = 0;
  int acc_dut = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the distance definition.
  function automatic logic [31:0] calc(input logic [31:0] sl, input logic [31:0] so,
                                       input logic [31:0] dl, input logic [31:0] dn,
                                       input longint kl, input longint kn, input int fr);
    longint a, b, s;
    a = longint'($signed(sl)) - longint'($signed(dl));
    b = longint'($signed(so)) - longint'($signed(dn));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    s = (a * kl + b * kn) >> fr;
    if (s > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    return s[31:0];
  endfunction

  typedef struct {
    int          left;
    logic [31:0] val;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] fifo_m[$];

  // Model and per-cycle comparison; inputs are stable here and apply at the next edge.
  always @(negedge ap_clk) begin : cmp_blk
    logic  exp_vld;
    logic  exp_ready;
    pend_t head;
    if (ap_rst) begin
      pend_q.delete();
      fifo_m.delete();
      check("rst_vld",   64'(out_r_ap_vld), 64'd0);
      check("rst_out",   64'(out_r),        64'd0);
      check("rst_empty", 64'(empty),        64'd1);
      check("rst_full",  64'(full),         64'd0);
      check("rst_size",  64'(size),         64'd0);
      check("rst_ready", 64'(ap_ready),     64'd0);
    end else begin
      foreach (pend_q[i]) pend_q[i].left--;
      exp_vld   = (pend_q.size() > 0) && (pend_q[0].left == 0);
      exp_ready = (fifo_m.size() + pend_q.size()) < DEPTH;
      check("vld",   64'(out_r_ap_vld), 64'(exp_vld));
      check("done",  64'(ap_done),      64'(exp_vld));
      if (exp_vld) check("out_r", 64'(out_r), 64'(pend_q[0].val));
      check("size",  64'(size),     64'(fifo_m.size()));
      check("empty", 64'(empty),    64'(fifo_m.size() == 0));
      check("full",  64'(full),     64'(fifo_m.size() == DEPTH));
      check("ready", 64'(ap_ready), 64'(exp_ready));
      check("idle",  64'(ap_idle),  64'(pend_q.size() == 0 && !ap_start));
      if (fifo_m.size() > 0) check("rd_data", 64'(rd_data), 64'(fifo_m[0]));
      if (ap_start && ap_ready) acc_dut++;
      if (ap_start && exp_ready)
        pend_q.push_back('{LAT, calc(src_lat_V, src_lon_V, dst_lat_V, dst_lon_V, 1, 1, 0)});
      if (rd_en && fifo_m.size() > 0) void'(fifo_m.pop_front());
      if (exp_vld) begin
        head = pend_q.pop_front();
        fifo_m.push_back(head.val);
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(input int sl, input int so, input int dl, input int dn);
    src_lat_V = sl; src_lon_V = so; dst_lat_V = dl; dst_lon_V = dn;
  endtask

  task automatic wait_vld(input string nm, output int k);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge ap_clk);
      if (out_r_ap_vld) begin k = i; break; end
    end
    check({nm, "_seen"}, 64'(k != 0), 64'd1);
  endtask

  task automatic wait_vld2(input string nm, output int k);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge ap_clk);
      if (out_r_ap_vld2) begin k = i; break; end
    end
    check({nm, "_seen"}, 64'(k != 0), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, acc0, n_after;
    logic [31:0] got[$];

    repeat (3) @(negedge ap_clk);
    check("t0_idle_in_reset", 64'(ap_idle), 64'd1);
    tick();
    ap_rst = 1'b0;
    tick();

    // 1) single request, latency and FIFO fall-through
    set_req(10, 20, 4, 25);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    wait_vld("t1", k);
    check("t1_latency", 64'(k), 64'd3);
    check("t1_out",     64'(out_r), 64'd11);
    @(negedge ap_clk);
    check("t1_empty",   64'(empty), 64'd0);
    check("t1_rd_data", 64'(rd_data), 64'd11);
    check("t1_size",    64'(size), 64'd1);
    tick(); rd_en = 1'b1;
    tick(); rd_en = 1'b0;

    // 2) extreme latitude difference, unit weights and weighted saturation
    set_req(32'h8000_0000, 0, 32'h7FFF_FFFF, 0);
    ap_start = 1'b1; start2 = 1'b1;
    tick();
    ap_start = 1'b0; start2 = 1'b0;
    wait_vld("t2", k);
    check("t2_out_k1",     64'(out_r), 64'hFFFF_FFFF);
    check("t2_vld_k3",     64'(out_r_ap_vld2), 64'd1);
    check("t2_out_k3_sat", 64'(out_r2), 64'hFFFF_FFFF);
    tick(); rd_en = 1'b1;
    tick(); rd_en = 1'b0;
    set_req(10, 20, 4, 25);
    start2 = 1'b1; tick(); start2 = 1'b0;
    wait_vld2("t2b", k);
    check("t2_out_k3_a", 64'(out_r2), 64'd43);
    set_req(-7, 100, 3, -50);
    tick(); start2 = 1'b1; tick(); start2 = 1'b0;
    wait_vld2("t2c", k);
    check("t2_out_k3_b", 64'(out_r2), 64'd780);
    tick();

    // 3) 70 consecutive starts, no pops: exactly 64 accepted
    acc0 = acc_dut;
    for (int i = 0; i < 70; i++) begin
      set_req(i * 1000, -i, 7, i * i);
      ap_start = 1'b1;
      tick();
    end
    ap_start = 1'b0;
    repeat (LAT + 2) tick();
    @(negedge ap_clk);
    check("t3_accepted", 64'(acc_dut - acc0), 64'd64);
    check("t3_full",     64'(full), 64'd1);
    check("t3_size",     64'(size), 64'd64);
    check("t3_ready",    64'(ap_ready), 64'd0);
    tick(); rd_en = 1'b1;
    @(negedge ap_clk);
    check("t3_no_bypass", 64'(ap_ready), 64'd0);
    tick(); rd_en = 1'b0;
    @(negedge ap_clk);
    check("t3_ready_back", 64'(ap_ready), 64'd1);
    check("t3_size_63",    64'(size), 64'd63);

    // 4) push and pop in the same cycle near capacity, then drain in order
    tick();
    set_req(100, 200, 50, 50);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick();
    tick();
    rd_en = 1'b1;
    @(negedge ap_clk);
    check("t4_vld",      64'(out_r_ap_vld), 64'd1);
    check("t4_out",      64'(out_r), 64'd200);
    check("t4_size_pre", 64'(size), 64'd63);
    tick();
    @(negedge ap_clk);
    check("t4_size_hold", 64'(size), 64'd63);
    repeat (63) tick();
    @(negedge ap_clk);
    check("t4_drained_empty", 64'(empty), 64'd1);

    // 5) pops while empty, then three results through a continuously popped FIFO
    tick();
    @(negedge ap_clk);
    check("t5_size_no_underflow", 64'(size), 64'd0);
    set_req(0, 0, 1, 2);   ap_start = 1'b1; tick();
    set_req(5, 5, 5, 5);   tick();
    set_req(-3, -3, 3, 3); tick();
    ap_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      if (out_r_ap_vld) got.push_back(out_r);
    end
    check("t5_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      check("t5_r0", 64'(got[0]), 64'd3);
      check("t5_r1", 64'(got[1]), 64'd0);
      check("t5_r2", 64'(got[2]), 64'd12);
    end
    check("t5_empty_end", 64'(empty), 64'd1);
    tick(); rd_en = 1'b0;

    // 6) reset with two in flight and five queued
    for (int i = 0; i < 7; i++) begin
      set_req(i, 2 * i, 0, 0);
      ap_start = 1'b1;
      tick();
    end
    ap_start = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (size == 7'd5) begin k = 1; break; end
    end
    check("t6_size5_seen", 64'(k), 64'd1);
    check("t6_busy",       64'(ap_idle), 64'd0);
    #1 ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    #1 ap_rst = 1'b0;
    n_after = 0;
    repeat (8) begin
      @(negedge ap_clk);
      if (out_r_ap_vld) n_after++;
    end
    check("t6_no_vld_after", 64'(n_after), 64'd0);
    check("t6_idle",         64'(ap_idle), 64'd1);
    check("t6_empty",        64'(empty), 64'd1);
    check("t6_size",         64'(size), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
